// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one four-lane (4 x 8-bit) RAM between the CPU fetch port
//            and its load/store port. Round-robin arbitration, store byte
//            enables with lane replication, load lane extraction with
//            sign/zero extension, misaligned/illegal access flagging.
// Ports    : clk_in, reset (async, active-low)
//            if_req/if_addr -> if_ack/if_rdata        fetch port
//            d_req/d_we/d_size/d_sext/d_addr/d_wdata
//                           -> d_ack/d_err/d_rdata    load/store port
//            ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata  RAM side
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_sext,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_t;

  localparam logic c_LAST_DATA  = 1'b1;
  localparam logic c_LAST_FETCH = 1'b0;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last;       // port granted most recently
  logic [1:0]  r_lane;       // captured d_addr[1:0]
  logic [1:0]  r_size;
  logic        r_sext;
  logic        r_err;
  logic        r_we;

  logic        w_grant_if;
  logic        w_grant_d;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Word-address wrap: the bits above the RAM range and the fetch byte
  // offset are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  // Misalignment check and store lane steering.
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata_rep  = d_wdata;
    case (d_size)
      2'b00: begin
        w_be        = 4'b0001 << d_addr[1:0];
        w_wdata_rep = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = d_addr[0];
        w_be         = d_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep  = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        w_misaligned = |d_addr[1:0];
      end
      default: begin
        w_misaligned = 1'b1;
      end
    endcase
  end

  // Next-state, grant and RAM/ack outputs.
  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_addr     = '0;
    ram_wdata    = '0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the port that did not win last time gets the RAM.
        if (if_req && (!d_req || (r_last == c_LAST_DATA))) begin
          w_grant_if   = 1'b1;
          w_next_state = IF_WAIT;
          ram_en       = 1'b1;
          ram_addr     = if_addr[ADDR_W+1:2];
        end else if (d_req) begin
          w_grant_d    = 1'b1;
          w_next_state = D_WAIT;
          // A misaligned request still consumes the grant but never
          // touches the RAM.
          if (!w_misaligned) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[ADDR_W+1:2];
            if (d_we) begin
              ram_we    = w_be;
              ram_wdata = w_wdata_rep;
            end
          end
        end
      end
      IF_WAIT: begin
        if_ack       = 1'b1;
        w_next_state = IDLE;
      end
      D_WAIT: begin
        d_ack        = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    // The RAM side is combinational from the requests, so it must be
    // forced quiet while reset is held.
    if (!reset) begin
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  // Load lane extraction from the word returned by the RAM.
  always_comb begin
    w_byte = ram_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = ram_rdata;
    endcase
  end

  assign if_rdata = if_ack ? ram_rdata : 32'd0;
  assign d_err    = d_ack & r_err;
  assign d_rdata  = (d_ack && !r_err && !r_we) ? w_load : 32'd0;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= c_LAST_DATA;
      r_lane  <= 2'b00;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_if) begin
        r_last <= c_LAST_FETCH;
      end else if (w_grant_d) begin
        r_last <= c_LAST_DATA;
        r_lane <= d_addr[1:0];
        r_size <= d_size;
        r_sext <= d_sext;
        r_err  <= w_misaligned;
        r_we   <= d_we;
      end
    end
  end

endmodule
`default_nettype wire
